// File: rtl/axis_tpg_burst_scheduler.sv
// AXI-Stream test-pattern burst scheduler: frames a generator stream into
// packets/bursts with tlast insertion, inter-burst gaps and graceful stop.
// Ports: m_axis_aclk/m_axis_aresetn; start/stop control; pkt_len,
// pkts_per_burst, gap_cycles, num_bursts config; s_axis_* from generator,
// m_axis_* downstream (zero latency); gen_enable, busy, done, cfg_err,
// burst_count status.
module axis_tpg_burst_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_aresetn,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CNT_WIDTH-1:0]  pkt_len,
  input  logic [CNT_WIDTH-1:0]  pkts_per_burst,
  input  logic [CNT_WIDTH-1:0]  gap_cycles,
  input  logic [CNT_WIDTH-1:0]  num_bursts,
  output logic                  gen_enable,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [CNT_WIDTH-1:0]  burst_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t state_q, state_d;

  logic [CNT_WIDTH-1:0] pkt_len_q, pkt_len_d;
  logic [CNT_WIDTH-1:0] ppb_q, ppb_d;
  logic [CNT_WIDTH-1:0] gap_q, gap_d;
  logic [CNT_WIDTH-1:0] nb_q, nb_d;
  logic [CNT_WIDTH-1:0] beat_q, beat_d;
  logic [CNT_WIDTH-1:0] pkt_q, pkt_d;
  logic [CNT_WIDTH-1:0] burst_q, burst_d;
  logic [CNT_WIDTH-1:0] gcnt_q, gcnt_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 done_q, done_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 run;
  logic                 xfer;
  logic                 last_beat;
  logic                 last_pkt;
  logic                 stop_now;
  logic [CNT_WIDTH-1:0] burst_inc;

  assign run       = (state_q == S_RUN);
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = s_axis_tvalid & run;
  assign s_axis_tready = m_axis_tready & run;
  assign xfer      = m_axis_tvalid & m_axis_tready;
  assign last_beat = (beat_q == pkt_len_q - ONE);
  assign last_pkt  = (pkt_q == ppb_q - ONE);
  // A stop landing on a packet's last beat still ends the run there.
  assign stop_now  = stop_pend_q | stop;
  assign burst_inc = burst_q + ONE;

  assign m_axis_tlast = run & last_beat;
  assign gen_enable   = run;
  assign busy         = run | (state_q == S_GAP);
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;
  assign burst_count  = burst_q;

  always_comb begin
    state_d     = state_q;
    pkt_len_d   = pkt_len_q;
    ppb_d       = ppb_q;
    gap_d       = gap_q;
    nb_d        = nb_q;
    beat_d      = beat_q;
    pkt_d       = pkt_q;
    burst_d     = burst_q;
    gcnt_d      = gcnt_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          if (pkt_len == '0 || pkts_per_burst == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            pkt_len_d = pkt_len;
            ppb_d     = pkts_per_burst;
            gap_d     = gap_cycles;
            nb_d      = num_bursts;
            beat_d    = '0;
            pkt_d     = '0;
            burst_d   = '0;
            state_d   = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (stop) stop_pend_d = 1'b1;
        if (xfer) begin
          beat_d = beat_q + ONE;
          if (last_beat) begin
            beat_d = '0;
            if (last_pkt) begin
              pkt_d   = '0;
              burst_d = burst_inc;
              if (stop_now || (nb_q != '0 && burst_inc == nb_q)) begin
                state_d     = S_IDLE;
                done_d      = 1'b1;
                stop_pend_d = 1'b0;
              end else if (gap_q != '0) begin
                state_d = S_GAP;
                gcnt_d  = gap_q;
              end
            end else begin
              pkt_d = pkt_q + ONE;
              if (stop_now) begin
                state_d     = S_IDLE;
                done_d      = 1'b1;
                stop_pend_d = 1'b0;
              end
            end
          end
        end
      end
      S_GAP: begin
        if (stop) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          stop_pend_d = 1'b0;
        end else if (gcnt_q == ONE) begin
          state_d = S_RUN;
        end else begin
          gcnt_d = gcnt_q - ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q     <= S_IDLE;
      pkt_len_q   <= '0;
      ppb_q       <= '0;
      gap_q       <= '0;
      nb_q        <= '0;
      beat_q      <= '0;
      pkt_q       <= '0;
      burst_q     <= '0;
      gcnt_q      <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pkt_len_q   <= pkt_len_d;
      ppb_q       <= ppb_d;
      gap_q       <= gap_d;
      nb_q        <= nb_d;
      beat_q      <= beat_d;
      pkt_q       <= pkt_d;
      burst_q     <= burst_d;
      gcnt_q      <= gcnt_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_axis_tpg_burst_scheduler.sv
// Bench for axis_tpg_burst_scheduler: table of run configs plus
// hand-written stop/gap/reset sequences, beats checked via a queue.
module tb_axis_tpg_burst_scheduler;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk;
  logic          rstn;
  logic          start;
  logic          stop;
  logic [CW-1:0] pkt_len;
  logic [CW-1:0] pkts_per_burst;
  logic [CW-1:0] gap_cycles;
  logic [CW-1:0] num_bursts;
  logic          gen_enable;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic [CW-1:0] burst_count;

  axis_tpg_burst_scheduler #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .m_axis_aclk   (clk),
    .m_axis_aresetn(rstn),
    .start         (start),
    .stop          (stop),
    .pkt_len       (pkt_len),
    .pkts_per_burst(pkts_per_burst),
    .gap_cycles    (gap_cycles),
    .num_bursts    (num_bursts),
    .gen_enable    (gen_enable),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .burst_count   (burst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  typedef struct {
    int pl;
    int ppb;
    int gap;
    int nb;
    bit bp;
    bit err;
    int beats;
    int bursts;
    int idle;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[6];

  int vectors = 0;
  int miscompares = 0;
  int beats, idle_cyc, done_cnt, err_cnt, sr_err, busy_cnt;
  int xfer_total = 0;
  logic [31:0] src_data = '0;
  bit bp = 1'b0;
  logic tog = 1'b1;

  assign s_axis_tdata  = src_data;
  assign s_axis_tvalid = 1'b1;
  assign m_axis_tready = bp ? tog : 1'b1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    beat_t e;
    if (m_axis_tvalid && m_axis_tready) begin
      check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat_data_last", {31'd0, m_axis_tlast, m_axis_tdata},
              {31'd0, e.l, e.d});
      end
      beats++;
      xfer_total++;
    end else if (busy) begin
      idle_cyc++;
    end
    if (done) done_cnt++;
    if (cfg_err) err_cnt++;
    if (busy) busy_cnt++;
    if (gen_enable && (s_axis_tready !== m_axis_tready)) sr_err++;
  end

  // Source advances only after an accepted beat.
  always @(posedge clk) begin
    #1;
    src_data = 32'(xfer_total);
    tog = ~tog;
  end

  task automatic clear_counters();
    beats = 0;
    idle_cyc = 0;
    done_cnt = 0;
    err_cnt = 0;
    sr_err = 0;
    busy_cnt = 0;
  endtask

  task automatic push_pkts(input int pl, input int npkts);
    logic [31:0] base;
    base = src_data;
    for (int i = 0; i < pl * npkts; i++)
      exp_q.push_back('{base + 32'(i), (i % pl) == pl - 1});
  endtask

  task automatic do_start(input int pl, input int ppb, input int gap,
                          input int nb);
    @(posedge clk);
    #1;
    pkt_len = CW'(pl);
    pkts_per_burst = CW'(ppb);
    gap_cycles = CW'(gap);
    num_bursts = CW'(nb);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (beats < target && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("wait_beats_bound", 64'(beats >= target), 64'd1);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_idle_bound", 64'(n < 3000), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    clear_counters();
    exp_q.delete();
    if (!v.err) push_pkts(v.pl, v.ppb * v.nb);
    bp = v.bp;
    do_start(v.pl, v.ppb, v.gap, v.nb);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    bp = 1'b0;
    check($sformatf("%s_cfg_err", tag), 64'(err_cnt), 64'(v.err));
    check($sformatf("%s_beats", tag), 64'(beats), 64'(v.beats));
    check($sformatf("%s_qempty", tag), 64'(exp_q.size()), 64'd0);
    if (v.err) begin
      check($sformatf("%s_busy", tag), 64'(busy_cnt), 64'd0);
    end else begin
      check($sformatf("%s_done", tag), 64'(done_cnt), 64'd1);
      check($sformatf("%s_bursts", tag), 64'(burst_count), 64'(v.bursts));
      check($sformatf("%s_sready", tag), 64'(sr_err), 64'd0);
      if (v.idle >= 0)
        check($sformatf("%s_idle", tag), 64'(idle_cyc), 64'(v.idle));
    end
  endtask

  initial begin
    vecs[0] = '{4, 2, 3, 2, 1'b0, 1'b0, 16, 2, 3};
    vecs[1] = '{4, 2, 3, 2, 1'b1, 1'b0, 16, 2, -1};
    vecs[2] = '{0, 2, 3, 2, 1'b0, 1'b1, 0, 0, -1};
    vecs[3] = '{4, 0, 1, 1, 1'b0, 1'b1, 0, 0, -1};
    vecs[4] = '{2, 1, 0, 3, 1'b0, 1'b0, 6, 3, 0};
    vecs[5] = '{3, 3, 2, 1, 1'b0, 1'b0, 9, 1, 0};

    rstn = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    pkt_len = '0;
    pkts_per_burst = '0;
    gap_cycles = '0;
    num_bursts = '0;
    clear_counters();
    repeat (3) @(posedge clk);
    #1;
    check("rst_gen_enable", 64'(gen_enable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_sready", 64'(s_axis_tready), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_burst_count", 64'(burst_count), 64'd0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Graceful stop mid-burst at beat 3 of packet 1.
    clear_counters();
    exp_q.delete();
    push_pkts(8, 2);
    do_start(8, 4, 2, 0);
    wait_beats(11);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    wait_beats(16);
    check("gstop_busy", 64'(busy), 64'd0);
    check("gstop_done", 64'(done), 64'd1);
    check("gstop_tvalid", 64'(m_axis_tvalid), 64'd0);
    @(posedge clk);
    #1;
    check("gstop_done_pulse", 64'(done), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("gstop_beats", 64'(beats), 64'd16);
    check("gstop_done_cnt", 64'(done_cnt), 64'd1);
    check("gstop_bursts", 64'(burst_count), 64'd0);

    // Start ignored in RUN, then stop at gap cycle 4.
    clear_counters();
    exp_q.delete();
    push_pkts(2, 2);
    do_start(2, 2, 10, 0);
    wait_beats(1);
    pkt_len = CW'(5);
    pkts_per_burst = CW'(1);
    gap_cycles = CW'(0);
    num_bursts = CW'(1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_beats(4);
    check("gap_gen_enable", 64'(gen_enable), 64'd0);
    check("gap_busy", 64'(busy), 64'd1);
    check("gap_bursts", 64'(burst_count), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("gap4_busy", 64'(busy), 64'd1);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    check("gstop2_busy", 64'(busy), 64'd0);
    check("gstop2_done", 64'(done), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check("gstop2_beats", 64'(beats), 64'd4);
    check("gstop2_done_cnt", 64'(done_cnt), 64'd1);
    check("gstop2_bursts", 64'(burst_count), 64'd1);
    check("gstop2_qempty", 64'(exp_q.size()), 64'd0);

    // Stop on the last beat of the first packet.
    clear_counters();
    exp_q.delete();
    push_pkts(4, 1);
    do_start(4, 3, 1, 0);
    wait_beats(3);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    check("lstop_busy", 64'(busy), 64'd0);
    check("lstop_done", 64'(done), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check("lstop_beats", 64'(beats), 64'd4);
    check("lstop_qempty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset between edges, mid-packet.
    clear_counters();
    exp_q.delete();
    push_pkts(4, 2);
    do_start(4, 2, 0, 1);
    wait_beats(2);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_gen_enable", 64'(gen_enable), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("arst_tlast", 64'(m_axis_tlast), 64'd0);
    check("arst_bursts", 64'(burst_count), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("arst_no_done", 64'(done_cnt), 64'd0);
    run_vec('{4, 2, 0, 1, 1'b0, 1'b0, 8, 1, 0}, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
